// File: rtl/dat_mem_stk.sv
// dat_mem_stk: data memory with a registered read port and a downward-growing
// hardware stack at the top of the address space. Stack operations take
// priority over random access. Any request that loses arbitration is reported
// in a sticky collision flag.
module dat_mem_stk #(
   parameter int DW       = 8,
   parameter int AW       = 8,
   parameter int STK_SIZE = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          MemRead,
   input  logic          MemWrite,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] dat_in,
   input  logic          Push,
   input  logic          Pop,
   input  logic          err_clr,
   output logic [DW-1:0] dat_out,
   output logic          rd_valid,
   output logic [AW-1:0] sp,
   output logic          full,
   output logic          empty,
   output logic [2:0]    err
);

   localparam int DEPTH = 2**AW;

   // Empty stack points at the top word. A full stack points STK_SIZE words lower.
   localparam logic [AW-1:0] SP_TOP  = AW'(DEPTH - 1);
   localparam logic [AW-1:0] SP_FULL = AW'(DEPTH - 1 - STK_SIZE);

   logic [DW-1:0] core [DEPTH];

   logic          do_pop, do_push, do_ram;
   logic          pop_ok, push_ok;
   logic          mem_we, rd_en;
   logic [AW-1:0] mem_wa, rd_a, sp_inc, sp_nxt;
   logic [2:0]    err_set;

   assign empty  = (sp == SP_TOP);
   assign full   = (sp == SP_FULL);
   assign sp_inc = sp + AW'(1);

   // Arbitration: Pop beats Push, and any stack op beats random access.
   always_comb begin
      do_pop  = Pop;
      do_push = Push & ~Pop;
      do_ram  = ~Push & ~Pop;
      pop_ok  = do_pop & ~empty;
      push_ok = do_push & ~full;

      mem_we  = push_ok | (do_ram & MemWrite);
      mem_wa  = do_push ? sp : addr;
      rd_en   = pop_ok | (do_ram & MemRead);
      rd_a    = do_pop ? sp_inc : addr;

      sp_nxt  = sp;
      if (pop_ok)       sp_nxt = sp_inc;
      else if (push_ok) sp_nxt = sp - AW'(1);

      // [2] covers a Push lost to a Pop and a RAM access lost to any stack op
      err_set[0] = do_push & full;
      err_set[1] = do_pop & empty;
      err_set[2] = (Push & Pop) | ((Push | Pop) & (MemRead | MemWrite));
   end

   // Storage array. It is deliberately left unreset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (mem_we) core[mem_wa] <= dat_in;
   end

   // Read port, stack pointer and sticky errors. The read samples the
   // pre-edge array contents, so read-during-write returns the old data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sp       <= SP_TOP;
         dat_out  <= '0;
         rd_valid <= 1'b0;
         err      <= '0;
      end else begin
         sp       <= sp_nxt;
         rd_valid <= rd_en;
         if (rd_en) dat_out <= core[rd_a];
         err      <= (err & ~{3{err_clr}}) | err_set;
      end
   end

endmodule

// File: tb/tb_dat_mem_stk.sv
// tb_dat_mem_stk: directed vectors with hand-computed expectations for the
// data memory / hardware stack.
module tb_dat_mem_stk;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       MemRead = 1'b0, MemWrite = 1'b0, Push = 1'b0, Pop = 1'b0, err_clr = 1'b0;
   logic [7:0] addr = '0, dat_in = '0;
   logic [7:0] dat_out, sp;
   logic       rd_valid, full, empty;
   logic [2:0] err;

   int n_vec = 0;
   int n_err = 0;

   dat_mem_stk #(.DW(8), .AW(8), .STK_SIZE(16)) dut (
      .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
      .addr(addr), .dat_in(dat_in), .Push(Push), .Pop(Pop), .err_clr(err_clr),
      .dat_out(dat_out), .rd_valid(rd_valid), .sp(sp), .full(full),
      .empty(empty), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      MemRead = 0; MemWrite = 0; Push = 0; Pop = 0; err_clr = 0;
   endtask

   task automatic op(input logic rd, input logic wr, input logic pu, input logic po,
                     input logic [7:0] a, input logic [7:0] d);
      MemRead = rd; MemWrite = wr; Push = pu; Pop = po; addr = a; dat_in = d;
      tick();
      clr_in();
   endtask

   task automatic do_clr();
      err_clr = 1;
      tick();
      clr_in();
   endtask

   initial begin
      // power-on reset
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // 1: reset asserted between edges while a read result is live
      op(0, 0, 1, 0, 8'h00, 8'hA1);
      op(1, 0, 0, 0, 8'hFF, 8'h00);
      chk("pre_rst_rv", rd_valid, 1);
      chk("pre_rst_dat", dat_out, 8'hA1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_sp", sp, 8'hFF);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_err", err, 0);
      chk("rst_dat", dat_out, 0);
      chk("rst_rv", rd_valid, 0);
      #1 reset_n = 1'b1;

      // 2: random access, read-first on simultaneous read/write
      op(0, 1, 0, 0, 8'h10, 8'hA5);
      op(1, 0, 0, 0, 8'h10, 8'h00);
      chk("ra_dat", dat_out, 8'hA5);
      chk("ra_rv", rd_valid, 1);
      tick();
      chk("ra_idle_rv", rd_valid, 0);
      chk("ra_idle_dat", dat_out, 8'hA5);
      op(1, 1, 0, 0, 8'h10, 8'h3C);
      chk("rw_first", dat_out, 8'hA5);
      chk("rw_rv", rd_valid, 1);
      op(1, 0, 0, 0, 8'h10, 8'h00);
      chk("rw_after", dat_out, 8'h3C);
      chk("ra_err", err, 0);

      // 3: LIFO
      op(0, 0, 1, 0, 8'h00, 8'h01);
      op(0, 0, 1, 0, 8'h00, 8'h02);
      op(0, 0, 1, 0, 8'h00, 8'h03);
      chk("lifo_sp", sp, 8'hFC);
      chk("lifo_empty", empty, 0);
      op(1, 0, 0, 0, 8'hFF, 8'h00); chk("core_ff", dat_out, 8'h01);
      op(1, 0, 0, 0, 8'hFE, 8'h00); chk("core_fe", dat_out, 8'h02);
      op(1, 0, 0, 0, 8'hFD, 8'h00); chk("core_fd", dat_out, 8'h03);
      chk("lifo_sp_hold", sp, 8'hFC);
      Pop = 1;
      tick(); chk("pop1", dat_out, 8'h03); chk("pop1_rv", rd_valid, 1);
      tick(); chk("pop2", dat_out, 8'h02); chk("pop2_rv", rd_valid, 1);
      tick(); chk("pop3", dat_out, 8'h01); chk("pop3_rv", rd_valid, 1);
      clr_in();
      chk("lifo_sp_end", sp, 8'hFF);
      chk("lifo_empty_end", empty, 1);

      // 4: overflow / underflow
      op(0, 1, 0, 0, 8'hEF, 8'h5A);
      for (int i = 0; i < 16; i++) op(0, 0, 1, 0, 8'h00, 8'(8'h40 + i));
      chk("ovf_full", full, 1);
      chk("ovf_sp", sp, 8'hEF);
      chk("ovf_err0", err, 3'b000);
      op(0, 0, 1, 0, 8'h00, 8'hEE);
      chk("ovf_err", err, 3'b001);
      chk("ovf_sp2", sp, 8'hEF);
      chk("ovf_full2", full, 1);
      op(1, 0, 0, 0, 8'hEF, 8'h00);
      chk("ovf_nowrite", dat_out, 8'h5A);
      op(0, 0, 0, 1, 8'h00, 8'h00);
      chk("ovf_pop_top", dat_out, 8'h4F);
      chk("ovf_notfull", full, 0);
      for (int i = 0; i < 15; i++) op(0, 0, 0, 1, 8'h00, 8'h00);
      chk("unf_last", dat_out, 8'h40);
      chk("unf_empty", empty, 1);
      op(0, 0, 0, 1, 8'h00, 8'h00);
      chk("unf_rv", rd_valid, 0);
      chk("unf_dat_hold", dat_out, 8'h40);
      chk("unf_err", err, 3'b011);
      chk("unf_sp", sp, 8'hFF);
      do_clr();
      chk("err_clr", err, 3'b000);

      // 5: collisions
      op(0, 1, 0, 0, 8'h20, 8'h11);
      op(0, 1, 1, 0, 8'h20, 8'h99);
      chk("col_sp", sp, 8'hFE);
      chk("col_err", err, 3'b100);
      op(1, 0, 0, 0, 8'h20, 8'h00);
      chk("col_core20", dat_out, 8'h11);
      do_clr();
      op(0, 0, 1, 1, 8'h00, 8'h55);
      chk("pp_dat", dat_out, 8'h99);
      chk("pp_rv", rd_valid, 1);
      chk("pp_sp", sp, 8'hFF);
      chk("pp_err", err, 3'b100);
      // set beats clear in the same cycle
      MemRead = 1; Push = 1; err_clr = 1; addr = 8'h00; dat_in = 8'h66;
      tick(); clr_in();
      chk("set_over_clr", err, 3'b100);
      do_clr();
      chk("err_clr2", err, 3'b000);
      op(0, 0, 0, 1, 8'h00, 8'h00);
      chk("pp_drain", dat_out, 8'h66);

      // 6: stack / random aliasing
      op(0, 0, 1, 0, 8'h00, 8'h77);
      op(1, 0, 0, 0, 8'hFF, 8'h00);
      chk("alias_dat", dat_out, 8'h77);
      chk("alias_sp", sp, 8'hFE);
      chk("alias_err", err, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
